piso_shift_serializer: RTL
==========================

# piso_shift_serializer

Parallel-in, serial-out transmitter that takes a WIDTH-bit word over a valid/ready handshake and emits it one bit per paced step, with a per-bit strobe and an end-of-word marker. It is the transmit end of the team's serial-in shift-register path. A left-shift receiver that samples sdata on svalid reassembles the original word unchanged when MSB_FIRST=1.

## Interface
- WIDTH, 4: word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.

- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word; equals (state == IDLE).
- load_data  input  WIDTH  parallel word to transmit.
- shift_en  input  1  pacing tick; one bit is emitted per cycle in which it is high during SHIFT.
- sdata  output  1  serial data bit; registered.
- svalid  output  1  one-cycle strobe marking sdata as a new bit; registered.
- slast  output  1  high together with svalid on the final bit of a word; registered.
- busy  output  1  word in progress; equals (state == SHIFT).

## Operation
- Reset (rstn=0 at a rising edge): state=IDLE, shift register=0, bit counter=0, sdata=0, svalid=0, slast=0. Therefore load_ready=1 and busy=0 from the first cycle after reset. Reset takes priority over every other input.
- States:
  - IDLE: load_ready=1.
    - load_valid=1: capture load_data into the shift register, set counter=WIDTH-1, go to SHIFT.
    - shift_en is ignored.
  - SHIFT: load_ready=0.
    - Each cycle with shift_en=1, register the next bit into sdata and set svalid=1.
    - The next bit is shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
    - Shift the register toward the emitted end and zero-fill the vacated bit.
    - slast=1 when counter==0, otherwise decrement the counter.
    - When counter==0, return to IDLE on the same edge.
    - Cycles with shift_en=0: svalid=0, slast=0, sdata holds its value, counter and shift register hold.
- In IDLE, svalid and slast are 0 and sdata holds the last emitted bit.
- load_valid during SHIFT is ignored. The upstream side holds the word until load_ready.
- Counter width is $clog2(WIDTH); the counter never wraps below 0.
- Reset mid-word aborts the word. No further svalid pulses occur, and no partial slast is produced.

## Timing
- Accept at edge N (IDLE, load_valid=1). The block is in SHIFT from N+1.
- The first bit is registered at the first edge M ≥ N+1 with shift_en=1, so svalid is high during cycle M+1. Minimum latency from accept to the first svalid is 2 cycles.
- With shift_en held at 1, svalid is high for WIDTH consecutive cycles and slast is high on the last of them.
- load_ready returns high in the same cycle the final svalid/slast is visible. The earliest next accept is on that cycle's closing edge, so the minimum word period is WIDTH+1 cycles.
- Outputs have no combinational path from inputs. load_ready and busy decode state only.

## Structure
- Shared package serial_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a default width constant SER_WIDTH=4, shared with the receiving shift register.
- The block is a single module with no sub-module. The counter and shift register are small enough to stay inline.

## Test plan
- WIDTH=4, MSB_FIRST=1, shift_en=1 constant, load 4'b1011 -> svalid high 4 consecutive cycles starting 2 cycles after accept; sdata=1,0,1,1; slast only on the 4th; load_ready high again in that same cycle.
- Loopback: connect sdata/svalid to a 4-bit left-shift receiver enabled by svalid, then send 4'b0110 and 4'b1001 back-to-back -> receiver holds 4'b0110 after the first slast and 4'b1001 after the second.
- shift_en pattern 1,0,0,1,1,0,1 with load 4'b1100 -> svalid pulses only after the 1-cycles; sdata=1,1,0,0; sdata held during the gaps.
- MSB_FIRST=0, load 4'b0001, shift_en=1 -> sdata=1,0,0,0 with slast on the 4th bit.
- load_valid held high with 4'b1111 then 4'b0000 while busy -> the second word is not accepted until load_ready=1; exactly 4 svalid pulses per accepted word.
- rstn low for one edge after 2 bits of 4'b1010 -> next cycle svalid=0, slast=0, sdata=0, load_ready=1; no further strobes until a new load.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register path: FSM encoding and the
// default word width used by both the transmit and receive ends.
package serial_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int unsigned SER_WIDTH = 4;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } ser_state_e;

endpackage

// File: rtl/piso_shift_serializer_if.sv
// Load handshake, pacing tick and serial output bundle of the serializer.
interface serial_if
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             sdata;
    logic             svalid;
    logic             slast;
    logic             busy;

    // Upstream/pacing side.
    modport master (
        output load_valid,
        output load_data,
        output shift_en,
        input  load_ready,
        input  sdata,
        input  svalid,
        input  slast,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  load_valid,
        input  load_data,
        input  shift_en,
        output load_ready,
        output sdata,
        output svalid,
        output slast,
        output busy
    );

endinterface

// File: rtl/piso_shift_serializer.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake
// and emits one registered bit per shift_en tick with a strobe and end-of-word flag.
module piso_shift_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    serial_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sdata_q, sdata_d;
    logic             svalid_q, svalid_d;
    logic             slast_q, slast_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sdata_d  = sdata_q;
        svalid_d = 1'b0;
        slast_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    shreg_d = bus.load_data;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.shift_en) begin
                    svalid_d = 1'b1;
                    // Emit from the leading end, then shift toward it with zero fill.
                    if (MSB_FIRST) begin
                        sdata_d = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sdata_d = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        slast_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sdata_q  <= 1'b0;
            svalid_q <= 1'b0;
            slast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
            slast_q  <= slast_d;
        end
    end

    assign bus.load_ready = (state_q == StIdle);
    assign bus.busy       = (state_q == StShift);
    assign bus.sdata      = sdata_q;
    assign bus.svalid     = svalid_q;
    assign bus.slast      = slast_q;

endmodule
